// File: rtl/param_shift_rotate_seq_pkg.sv
// Shared encodings for the shift/rotate register: step modes and burst FSM states.
package param_shift_rotate_seq_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD    = 3'b000,
    MODE_ROR     = 3'b001,
    MODE_ROL     = 3'b010,
    MODE_SHR     = 3'b011,
    MODE_SHL     = 3'b100,
    MODE_RING    = 3'b101,
    MODE_JOHNSON = 3'b110,
    MODE_ASR     = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Left-moving modes eject the MSB; every other mode ejects the LSB.
  function automatic logic is_left(input mode_e m);
    return (m == MODE_ROL) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/param_shift_rotate_seq_shift_step_comb.sv
// One combinational step of the shift/rotate register: next value and the bit that leaves q.
module param_shift_rotate_seq_shift_step_comb
  import param_shift_rotate_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_e            i_mode,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_out_bit
);

  always_comb begin
    o_next_q  = i_q;
    o_out_bit = is_left(i_mode) ? i_q[WIDTH-1] : i_q[0];
    case (i_mode)
      MODE_HOLD:    o_next_q = i_q;
      MODE_ROR:     o_next_q = {i_q[0], i_q[WIDTH-1:1]};
      MODE_ROL:     o_next_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_SHR:     o_next_q = {i_ser_in, i_q[WIDTH-1:1]};
      MODE_SHL:     o_next_q = {i_q[WIDTH-2:0], i_ser_in};
      // An all-zero ring would never recover, so it seeds a single one.
      MODE_RING:    o_next_q = (i_q == '0) ? WIDTH'(1) : {i_q[0], i_q[WIDTH-1:1]};
      MODE_JOHNSON: o_next_q = {~i_q[0], i_q[WIDTH-1:1]};
      MODE_ASR:     o_next_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
      default:      o_next_q = i_q;
    endcase
  end

endmodule

// File: rtl/param_shift_rotate_seq.sv
// Universal shift/rotate register with single-step operation and a counted burst engine.
module param_shift_rotate_seq
  import param_shift_rotate_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 4,
  parameter int RESET_VAL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [2:0]        i_mode,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic              i_ser_in,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_steps,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_ser_out,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  // Handshake: o_busy is high for every cycle a burst owns the register (steps
  // advance only when i_en is high); o_done pulses once after the last step.
  // A load during a burst aborts it without o_done; both flags are never high together.
  state_e            r_state;
  mode_e             r_mode;
  logic [STEP_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_q;
  logic              r_ser_out;
  logic              r_busy;
  logic              r_done;

  mode_e             w_mode;
  logic [WIDTH-1:0]  w_next_q;
  logic              w_out_bit;
  logic              w_moves;

  assign w_mode  = (r_state == ST_RUN) ? r_mode : mode_e'(i_mode);
  assign w_moves = (w_mode != MODE_HOLD);

  param_shift_rotate_seq_shift_step_comb #(.WIDTH(WIDTH)) u_shift_step_comb (
    .i_q      (r_q),
    .i_mode   (w_mode),
    .i_ser_in (i_ser_in),
    .o_next_q (w_next_q),
    .o_out_bit(w_out_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_HOLD;
      r_cnt     <= '0;
      r_q       <= RST_Q;
      r_ser_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_q <= i_load_data;
          end else if (i_start) begin
            r_mode <= mode_e'(i_mode);
            r_cnt  <= i_steps;
            if (i_steps == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end else if (i_en) begin
            r_q <= w_next_q;
            if (w_moves) r_ser_out <= w_out_bit;
          end
        end
        ST_RUN: begin
          if (i_load) begin
            r_q     <= i_load_data;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (i_en) begin
            r_q   <= w_next_q;
            r_cnt <= r_cnt - STEP_W'(1);
            if (w_moves) r_ser_out <= w_out_bit;
            if (r_cnt == STEP_W'(1)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_load) r_q <= i_load_data;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_q       = r_q;
  assign o_ser_out = r_ser_out;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_state   = r_state;

endmodule

// File: tb/tb_param_shift_rotate_seq.sv
// Bench for param_shift_rotate_seq: directed literal checks plus a random run against a behavioural model.
module tb_param_shift_rotate_seq;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_en = 1'b0;
  logic [2:0]    i_mode = 3'd0;
  logic          i_load = 1'b0;
  logic [W-1:0]  i_load_data = '0;
  logic          i_ser_in = 1'b0;
  logic          i_start = 1'b0;
  logic [SW-1:0] i_steps = '0;
  logic [W-1:0]  o_q;
  logic          o_ser_out;
  logic          o_busy;
  logic          o_done;
  logic [1:0]    o_state;

  int g_checks = 0;
  int g_errors = 0;

  param_shift_rotate_seq #(.WIDTH(W), .STEP_W(SW), .RESET_VAL(1)) dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_mode(i_mode), .i_load(i_load),
    .i_load_data(i_load_data), .i_ser_in(i_ser_in), .i_start(i_start), .i_steps(i_steps),
    .o_q(o_q), .o_ser_out(o_ser_out), .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    g_checks++;
    if (act !== exp) begin
      g_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: the register value, the last ejected bit, and how many
  // burst steps are still owed.
  logic [W-1:0] m_q;
  logic         m_ser;
  logic [2:0]   m_burst_mode;
  int           m_left;
  logic         m_done;

  function automatic void model_step(input logic [2:0] md);
    logic [W-1:0] q;
    q = m_q;
    case (md)
      3'd1: begin m_ser = q[0];   m_q = (q >> 1) | (q << (W-1)); end
      3'd2: begin m_ser = q[W-1]; m_q = (q << 1) | (q >> (W-1)); end
      3'd3: begin m_ser = q[0];   m_q = (q >> 1) | (W'(i_ser_in) << (W-1)); end
      3'd4: begin m_ser = q[W-1]; m_q = (q << 1) | W'(i_ser_in); end
      3'd5: begin m_ser = q[0];   m_q = (q == 0) ? W'(1) : ((q >> 1) | (q << (W-1))); end
      3'd6: begin m_ser = q[0];   m_q = (q >> 1) | (W'(~q[0]) << (W-1)); end
      3'd7: begin m_ser = q[0];   m_q = W'($signed(q) >>> 1); end
      default: ;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q = W'(1); m_ser = 1'b0; m_left = 0; m_done = 1'b0; m_burst_mode = 3'd0;
    end else begin
      logic was_done;
      was_done = m_done;
      m_done = 1'b0;
      if (i_load) begin
        m_q = i_load_data;
        m_left = 0;
      end else if (was_done) begin
      end else if (m_left > 0) begin
        if (i_en) begin
          model_step(m_burst_mode);
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end else if (i_start) begin
        m_burst_mode = i_mode;
        if (i_steps == 0) m_done = 1'b1;
        else m_left = int'(i_steps);
      end else if (i_en) begin
        model_step(i_mode);
      end
    end
  end

  // Scoreboard compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_q", 32'(o_q), 32'(m_q));
      check("cmp_ser_out", 32'(o_ser_out), 32'(m_ser));
      check("cmp_busy", 32'(o_busy), 32'(m_left > 0));
      check("cmp_done", 32'(o_done), 32'(m_done));
      check("cmp_busy_done_excl", 32'(o_busy & o_done), 32'd0);
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_en = 1'b0; i_mode = 3'd0; i_load = 1'b0; i_start = 1'b0; i_steps = '0; i_ser_in = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    clear_inputs();
    i_load = 1'b1; i_load_data = v;
    cyc();
    i_load = 1'b0;
  endtask

  logic [W-1:0] john_exp [9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F};

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (3) cyc();
    check("rst_q", 32'(o_q), 32'h01);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_ser", 32'(o_ser_out), 0);
    reset = 1'b0;
    cyc();

    // Single steps
    do_load(8'hA5);
    i_en = 1'b1; i_mode = 3'd1; cyc();
    check("ror_q", 32'(o_q), 32'hD2);
    check("ror_ser", 32'(o_ser_out), 1);
    do_load(8'h90);
    i_en = 1'b1; i_mode = 3'd7; cyc();
    check("asr_q", 32'(o_q), 32'hC8);

    // Burst ROL x3; live mode changed to HOLD after start
    do_load(8'h81);
    i_start = 1'b1; i_mode = 3'd2; i_steps = 4'd3; i_en = 1'b1; cyc();
    check("b_start_busy", 32'(o_busy), 1);
    check("b_start_q", 32'(o_q), 32'h81);
    i_start = 1'b0; i_mode = 3'd0;
    cyc(); check("b_q1", 32'(o_q), 32'h03);
    cyc(); check("b_q2", 32'(o_q), 32'h06); check("b_busy2", 32'(o_busy), 1);
    cyc(); check("b_q3", 32'(o_q), 32'h0C); check("b_done", 32'(o_done), 1);
    check("b_busy3", 32'(o_busy), 0);
    cyc(); check("b_done_clr", 32'(o_done), 0);

    // Burst with a two-cycle stall
    do_load(8'h81);
    i_start = 1'b1; i_mode = 3'd2; i_steps = 4'd3; i_en = 1'b1; cyc();
    i_start = 1'b0;
    cyc(); check("st_q1", 32'(o_q), 32'h03);
    i_en = 1'b0;
    cyc(); cyc(); check("st_hold_q", 32'(o_q), 32'h03); check("st_hold_busy", 32'(o_busy), 1);
    i_en = 1'b1;
    cyc(); check("st_q2", 32'(o_q), 32'h06); check("st_nodone", 32'(o_done), 0);
    cyc(); check("st_q3", 32'(o_q), 32'h0C); check("st_done", 32'(o_done), 1);

    // Johnson and ring
    do_load(8'h00);
    i_en = 1'b1; i_mode = 3'd6;
    for (int k = 0; k < 9; k++) begin
      cyc();
      check($sformatf("john_%0d", k), 32'(o_q), 32'(john_exp[k]));
    end
    do_load(8'h00);
    i_en = 1'b1; i_mode = 3'd5;
    cyc(); check("ring_seed", 32'(o_q), 32'h01);
    cyc(); check("ring_wrap", 32'(o_q), 32'h80);

    // Zero-step burst
    do_load(8'h5A);
    i_start = 1'b1; i_steps = 4'd0; i_mode = 3'd1; cyc();
    i_start = 1'b0;
    check("z_done", 32'(o_done), 1); check("z_busy", 32'(o_busy), 0); check("z_q", 32'(o_q), 32'h5A);
    cyc(); check("z_done_clr", 32'(o_done), 0); check("z_busy2", 32'(o_busy), 0);

    // start held during RUN is ignored
    do_load(8'h01);
    i_start = 1'b1; i_mode = 3'd2; i_steps = 4'd4; i_en = 1'b1; cyc();
    i_steps = 4'd1; i_mode = 3'd1;
    cyc(); cyc(); cyc();
    check("sr_q3", 32'(o_q), 32'h08); check("sr_busy", 32'(o_busy), 1);
    i_start = 1'b0;
    cyc(); check("sr_q4", 32'(o_q), 32'h10); check("sr_done", 32'(o_done), 1);
    cyc();

    // Load aborts a burst
    do_load(8'hC3);
    i_start = 1'b1; i_mode = 3'd1; i_steps = 4'd5; i_en = 1'b1; cyc();
    i_start = 1'b0;
    cyc(); check("ab_q1", 32'(o_q), 32'hE1);
    i_load = 1'b1; i_load_data = 8'h3C; cyc();
    i_load = 1'b0; i_en = 1'b0;
    check("ab_q", 32'(o_q), 32'h3C); check("ab_busy", 32'(o_busy), 0); check("ab_done", 32'(o_done), 0);
    cyc(); check("ab_done2", 32'(o_done), 0);

    // Async reset mid-burst
    i_start = 1'b1; i_mode = 3'd2; i_steps = 4'd5; i_en = 1'b1; cyc();
    i_start = 1'b0;
    cyc();
    #2 reset = 1'b1;
    #1 check("ar_q", 32'(o_q), 32'h01); check("ar_busy", 32'(o_busy), 0); check("ar_done", 32'(o_done), 0);
    cyc();
    reset = 1'b0;
    clear_inputs();
    cyc(); check("ar_done_after", 32'(o_done), 0); check("ar_q_after", 32'(o_q), 32'h01);

    // Random stimulus against the model
    for (int n = 0; n < 700; n++) begin
      i_en        = ($urandom_range(0, 3) != 0);
      i_mode      = 3'($urandom_range(0, 7));
      i_load      = ($urandom_range(0, 15) == 0);
      i_load_data = W'($urandom);
      i_ser_in    = 1'($urandom_range(0, 1));
      i_start     = ($urandom_range(0, 7) == 0);
      i_steps     = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end
      cyc();
    end

    clear_inputs();
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", g_checks, g_errors);
    $finish;
  end

endmodule

// File: doc/param_shift_rotate_seq.md
Name: param_shift_rotate_seq

Overview:
Parametrised universal shift/rotate register with eight step modes: rotate, logical shift with serial in, arithmetic shift, one-hot ring and Johnson. It supports single-step operation and a counted burst engine: a start pulse runs N steps autonomously, with busy/done handshake. It is the general-purpose shift/ring building block for the sequencing and pattern-generator exercises in the guide series.

Parameters:
WIDTH, 8, register width in bits (>= 2)
STEP_W, 4, width of the burst step-count input
RESET_VAL, 1, value loaded into q on reset (truncated to WIDTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  step enable; idle single-step when high; stalls a burst when low
mode  input  3  step mode (see Behaviour)
load  input  1  synchronous parallel load strobe
load_data  input  WIDTH  parallel load value
ser_in  input  1  serial input for logical shift modes
start  input  1  burst start strobe, sampled only in IDLE
steps  input  STEP_W  number of steps for a burst
q  output  WIDTH  register contents
ser_out  output  1  registered copy of the bit that left q on the most recent step
busy  output  1  high while a burst is in RUN
done  output  1  one-cycle pulse on burst completion

Behaviour:
- Reset is asynchronous and active-high on clk domain. It forces q=RESET_VAL, ser_out=0, busy=0, done=0, FSM=IDLE, and clears the latched mode and count. Reset mid-burst abandons the burst with no done pulse.
- Modes (next value from current q):
  - 000 HOLD: q unchanged.
  - 001 ROR: {q[0], q[W-1:1]}.
  - 010 ROL: {q[W-2:0], q[W-1]}.
  - 011 SHR: {ser_in, q[W-1:1]}.
  - 100 SHL: {q[W-2:0], ser_in}.
  - 101 RING: ROR; if q==0, next is 1 (self-start).
  - 110 JOHNSON: {~q[0], q[W-1:1]}.
  - 111 ASR: {q[W-1], q[W-1:1]}.
- ser_out on each step:
  - Takes q[0] for right-moving modes and q[W-1] for left-moving modes.
  - Is unchanged on HOLD, load, and idle cycles.
- Priority per cycle: reset > load > burst step > idle single step.
- FSM:
  - IDLE:
    - load=1: q<=load_data.
    - Else start=1: latch mode into mode_r and steps into cnt.
      - steps==0: go to DONE, q unchanged.
      - Else go to RUN. No step occurs in the start cycle.
    - Else en=1: apply one step of the live mode.
  - RUN (busy=1):
    - en=1: apply one step using mode_r and decrement cnt. When cnt==1 at the step, go to DONE.
    - en=0: stall; q and cnt hold.
    - load=1: q<=load_data, burst aborted to IDLE, no done pulse.
    - start and live mode are ignored.
  - DONE: done=1 for exactly one cycle, busy=0, no step, then IDLE. start in DONE is ignored.
- Latency:
  - Burst of N>0 with en held high: busy for N cycles starting the cycle after start, then done for 1 cycle.
  - steps=0: done the cycle after start.
- busy and done are registered outputs decoded from FSM state. They are never high together.

Decomposition:
- Shared package: mode encodings (MODE_HOLD..MODE_ASR) and FSM state encodings (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module shift_step_comb: purely combinational. Takes q, mode, ser_in; returns next_q and out_bit. It is instanced once and fed by the live mode or mode_r through a mux.

Test Plan:
- Reset, WIDTH=8 -> q=8'h01, busy=0, done=0, ser_out=0. Async assert mid-cycle clears immediately.
- load 8'hA5, then en=1 mode=ROR for one cycle -> q=8'hD2, ser_out=1. Next, mode=ASR on load 8'h90 -> q=8'hC8.
- load 8'h81, start with mode=ROL steps=3 -> busy for 3 cycles, q=03,06,0C, then done pulse, then IDLE. Drop en for 2 cycles mid-burst -> q holds, done delayed by 2.
- load 0, mode=JOHNSON 9 single steps -> 80,C0,E0,F0,F8,FC,FE,FF,7F. load 0, mode=RING -> 01 then 80.
- start steps=0 -> done next cycle, q unchanged, busy never high. start during RUN -> ignored, count unaffected.
- load 8'h3C during RUN of an ROR burst -> q=8'h3C next cycle, busy=0, no done. Reset during RUN -> q=RESET_VAL, no done.
